mux21_arb: RTL and testbench

- Upstream select stage for the 2:1 mux datapath.
- Arbitrates between two valid/ready request channels (A, B) using round-robin with a bounded burst length.
- Drives registered SEL, which also feeds downstream mux21 instances on sideband paths.
- Forwards the granted channel's data through a single-entry output register with valid/ready.

---
 rtl/mux21_arb.sv | 121 ++++++++++++
 tb/tb_mux21_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux21_arb.sv
// Round-robin 2:1 request arbiter with bounded bursts feeding a single-entry output register.
// Latency: 1 cycle IDLE arbitration, then 1 word/cycle; backpressure via combinational ready = !o_z_valid || i_z_ready.
module mux21_arb #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_a_data,
    input  logic         i_a_valid,
    output logic         o_a_ready,
    input  logic [W-1:0] i_b_data,
    input  logic         i_b_valid,
    output logic         o_b_ready,
    output logic         o_sel,
    output logic [W-1:0] o_z,
    output logic         o_z_valid,
    input  logic         i_z_ready,
    output logic         o_busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t         r_state;
    logic           r_sel;
    logic [W-1:0]   r_z;
    logic           r_z_valid;
    logic           r_last;
    logic [CW-1:0]  r_cnt;

    logic w_load_en;
    logic w_a_fire;
    logic w_b_fire;
    logic w_burst_end;

    assign w_load_en   = !r_z_valid || i_z_ready;
    assign o_a_ready   = (r_state == GNT_A) && w_load_en;
    assign o_b_ready   = (r_state == GNT_B) && w_load_en;
    assign w_a_fire    = i_a_valid && o_a_ready;
    assign w_b_fire    = i_b_valid && o_b_ready;
    assign w_burst_end = (r_cnt == CW'(MAX_BURST - 1));

    assign o_sel     = r_sel;
    assign o_z       = r_z;
    assign o_z_valid = r_z_valid;
    assign o_busy    = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_sel     <= 1'b0;
            r_z       <= '0;
            r_z_valid <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
        end else begin
            // A new load and a downstream accept in the same cycle keep valid high with no bubble.
            if (w_a_fire) begin
                r_z       <= i_a_data;
                r_z_valid <= 1'b1;
            end else if (w_b_fire) begin
                r_z       <= i_b_data;
                r_z_valid <= 1'b1;
            end else if (i_z_ready) begin
                r_z_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (i_a_valid && (!i_b_valid || r_last)) begin
                        r_state <= GNT_A;
                        r_sel   <= 1'b0;
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (i_b_valid) begin
                        r_state <= GNT_B;
                        r_sel   <= 1'b1;
                        r_last  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                GNT_A: begin
                    if (!i_a_valid || (w_a_fire && w_burst_end)) begin
                        if (i_b_valid) begin
                            r_state <= GNT_B;
                            r_sel   <= 1'b1;
                            r_last  <= 1'b1;
                            r_cnt   <= '0;
                        end else if (!i_a_valid) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= '0;
                        end
                    end else if (w_a_fire) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GNT_B: begin
                    if (!i_b_valid || (w_b_fire && w_burst_end)) begin
                        if (i_a_valid) begin
                            r_state <= GNT_A;
                            r_sel   <= 1'b0;
                            r_last  <= 1'b0;
                            r_cnt   <= '0;
                        end else if (!i_b_valid) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= '0;
                        end
                    end else if (w_b_fire) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux21_arb.sv
// Directed bench for mux21_arb: burst arbiter at MAX_BURST=4 and strict alternation at MAX_BURST=1.
module tb_mux21_arb;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_data, b_data, z;
    logic       a_valid, a_ready, b_valid, b_ready, sel, z_valid, z_ready, busy;
    logic [7:0] ca_data, cb_data, cz;
    logic       ca_valid, ca_ready, cb_valid, cb_ready, csel, cz_valid, cz_ready, cbusy;

    int total = 0;
    int bad   = 0;

    mux21_arb #(.W(8), .MAX_BURST(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_data(a_data), .i_a_valid(a_valid), .o_a_ready(a_ready),
        .i_b_data(b_data), .i_b_valid(b_valid), .o_b_ready(b_ready),
        .o_sel(sel), .o_z(z), .o_z_valid(z_valid), .i_z_ready(z_ready), .o_busy(busy)
    );

    mux21_arb #(.W(8), .MAX_BURST(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_data(ca_data), .i_a_valid(ca_valid), .o_a_ready(ca_ready),
        .i_b_data(cb_data), .i_b_valid(cb_valid), .o_b_ready(cb_ready),
        .o_sel(csel), .o_z(cz), .o_z_valid(cz_valid), .i_z_ready(cz_ready), .o_busy(cbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: record handshakes just before the edge, advance the sources just after it.
    task automatic cyc();
        logic fa, fb, fc, fd;
        #1;
        fa = a_valid && a_ready;
        fb = b_valid && b_ready;
        fc = ca_valid && ca_ready;
        fd = cb_valid && cb_ready;
        @(posedge clk);
        #1;
        if (fa) a_data = a_data + 8'd1;
        if (fb) b_data = b_data + 8'd1;
        if (fc) ca_data = ca_data + 8'd1;
        if (fd) cb_data = cb_data + 8'd1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; ca_valid = 1'b0; cb_valid = 1'b0;
        z_ready = 1'b1; cz_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (z !== 8'h00)    begin bad++; $display("FAIL reset_z got=%h exp=00", z); end
        total++; if (z_valid !== 1'b0) begin bad++; $display("FAIL reset_zvalid got=%b exp=0", z_valid); end
        total++; if (sel !== 1'b0)   begin bad++; $display("FAIL reset_sel got=%b exp=0", sel); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        apply_reset();
        a_data = 8'h01; a_valid = 1'b1;
        cyc();
        total++; if (busy !== 1'b1 || sel !== 1'b0 || z_valid !== 1'b0)
            begin bad++; $display("FAIL single_arb busy=%b sel=%b zv=%b exp 1,0,0", busy, sel, z_valid); end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            total++; if (z !== 8'(k) || z_valid !== 1'b1 || sel !== 1'b0)
                begin bad++; $display("FAIL single_beat%0d z=%h zv=%b sel=%b exp %h,1,0", k, z, z_valid, sel, 8'(k)); end
        end
        a_valid = 1'b0;
        cyc();
        total++; if (busy !== 1'b0 || z_valid !== 1'b0 || sel !== 1'b0)
            begin bad++; $display("FAIL single_idle busy=%b zv=%b sel=%b exp 0,0,0", busy, z_valid, sel); end
    endtask

    task automatic test_contention();
        logic [7:0] e;
        logic       es;
        int         g;
        apply_reset();
        a_data = 8'h10; b_data = 8'h20; a_valid = 1'b1; b_valid = 1'b1;
        cyc();
        for (int i = 0; i < 12; i++) begin
            cyc();
            g  = i / 4;
            e  = ((g % 2) == 0) ? 8'(8'h10 + (g / 2) * 4 + i % 4) : 8'(8'h20 + (g / 2) * 4 + i % 4);
            es = 1'(((i + 1) / 4) % 2);
            total++; if (z !== e || z_valid !== 1'b1 || sel !== es)
                begin bad++; $display("FAIL contention_beat%0d z=%h zv=%b sel=%b exp %h,1,%b", i, z, z_valid, sel, e, es); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        b_data = 8'h20; b_valid = 1'b1;
        cyc();
        cyc();
        cyc();
        total++; if (z !== 8'h21 || sel !== 1'b1)
            begin bad++; $display("FAIL bp_pre z=%h sel=%b exp 21,1", z, sel); end
        z_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (z !== 8'h21 || z_valid !== 1'b1 || b_ready !== 1'b0 || dut.r_cnt !== 3'd2)
                begin bad++; $display("FAIL bp_hold%0d z=%h zv=%b brdy=%b cnt=%0d exp 21,1,0,2", i, z, z_valid, b_ready, dut.r_cnt); end
        end
        z_ready = 1'b1;
        cyc();
        total++; if (z !== 8'h22 || z_valid !== 1'b1 || dut.r_cnt !== 3'd3)
            begin bad++; $display("FAIL bp_resume z=%h zv=%b cnt=%0d exp 22,1,3", z, z_valid, dut.r_cnt); end
        b_valid = 1'b0;
    endtask

    task automatic test_early_drop();
        apply_reset();
        a_data = 8'h30; b_data = 8'h40; a_valid = 1'b1; b_valid = 1'b1;
        cyc();
        cyc();
        cyc();
        total++; if (z !== 8'h31) begin bad++; $display("FAIL drop_pre z=%h exp 31", z); end
        a_valid = 1'b0;
        cyc();
        total++; if (sel !== 1'b1 || dut.r_cnt !== 3'd0 || dut.r_last !== 1'b1 || busy !== 1'b1)
            begin bad++; $display("FAIL drop_switch sel=%b cnt=%0d last=%b busy=%b exp 1,0,1,1", sel, dut.r_cnt, dut.r_last, busy); end
        cyc();
        total++; if (z !== 8'h40 || sel !== 1'b1)
            begin bad++; $display("FAIL drop_bbeat z=%h sel=%b exp 40,1", z, sel); end
        b_valid = 1'b0;
        cyc();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle busy=%b exp 0", busy); end
        a_valid = 1'b1; b_valid = 1'b1;
        cyc();
        cyc();
        total++; if (z !== 8'h32 || sel !== 1'b0)
            begin bad++; $display("FAIL drop_tie z=%h sel=%b exp 32,0", z, sel); end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        b_data = 8'h50; b_valid = 1'b1;
        cyc();
        cyc();
        cyc();
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (z !== 8'h00 || z_valid !== 1'b0 || sel !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL midrst_regs z=%h zv=%b sel=%b busy=%b exp 00,0,0,0", z, z_valid, sel, busy); end
        total++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
            begin bad++; $display("FAIL midrst_ready a=%b b=%b exp 0,0", a_ready, b_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_data = 8'h60; a_valid = 1'b1;
        cyc();
        total++; if (sel !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b0)
            begin bad++; $display("FAIL midrst_tie sel=%b ardy=%b brdy=%b exp 0,1,0", sel, a_ready, b_ready); end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_alternation();
        logic [7:0] e;
        int         na, nb;
        apply_reset();
        na = 0; nb = 0;
        ca_data = 8'h00; cb_data = 8'h80; ca_valid = 1'b1; cb_valid = 1'b1;
        cyc();
        for (int i = 0; i < 100; i++) begin
            cyc();
            e = ((i % 2) == 0) ? 8'(i / 2) : 8'(8'h80 + i / 2);
            if (cz_valid === 1'b1 && cz[7] === 1'b0) na++;
            if (cz_valid === 1'b1 && cz[7] === 1'b1) nb++;
            total++; if (cz !== e || cz_valid !== 1'b1)
                begin bad++; $display("FAIL alt_beat%0d z=%h zv=%b exp %h,1", i, cz, cz_valid, e); end
        end
        total++; if (na !== 50 || nb !== 50)
            begin bad++; $display("FAIL alt_counts a=%0d b=%0d exp 50,50", na, nb); end
        ca_valid = 1'b0; cb_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_data = 8'h00; b_data = 8'h00; ca_data = 8'h00; cb_data = 8'h00;
        a_valid = 1'b0; b_valid = 1'b0; ca_valid = 1'b0; cb_valid = 1'b0;
        z_ready = 1'b1; cz_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_drop();
        test_reset_mid();
        test_alternation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
